// File: rtl/hazard_ctrl.sv
// hazard_ctrl: backward-flowing stall/flush control for the 5-stage pipeline.
// Detects load-use hazards, taken-branch squashes and data-memory wait-states,
// sequences the resulting stalls with a small FSM and keeps saturating
// stall / flush statistics.
module hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Extra hold cycles after the first load-use bubble.
  localparam logic [2:0]       HOLD_INIT = 3'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_reg, state_next;
  state_t           ret_state_reg, ret_state_next;
  state_t           mode;
  logic [2:0]       hold_reg, hold_next;
  logic [CNT_W-1:0] stall_cycles_reg, flush_count_reg;

  logic freeze;
  logic lu;
  logic flush_event;
  logic pc_we, ifid_we, ifid_fl, idex_we, idex_bub, exmem_we;

  assign freeze = mem_req & ~mem_ready;

  // Load in ID/EX writes a register that the IF/ID instruction reads ($zero excluded).
  assign lu = idex_mem_read & (idex_rt != 5'd0) &
              ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

  // Next-state and pipeline control decode; MEM_WAIT resolves to the saved state once memory is ready.
  always_comb begin
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    ifid_fl        = 1'b0;
    idex_we        = 1'b1;
    idex_bub       = 1'b0;
    exmem_we       = 1'b1;
    flush_event    = 1'b0;
    state_next     = state_reg;
    ret_state_next = ret_state_reg;
    hold_next      = hold_reg;
    mode           = (state_reg == MEM_WAIT) ? ret_state_reg : state_reg;

    if ((state_reg == MEM_WAIT) && !mem_ready) begin
      // Whole pipeline frozen while the data memory is still busy.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
    end else if (freeze) begin
      // Freeze wins over everything; remember where to resume. Hold count is kept.
      pc_we          = 1'b0;
      ifid_we        = 1'b0;
      idex_we        = 1'b0;
      exmem_we       = 1'b0;
      ret_state_next = mode;
      state_next     = MEM_WAIT;
    end else if (mode == LU_HOLD) begin
      // Continue an in-progress load-use stall; EX holds a bubble so no branch here.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_bub   = 1'b1;
      hold_next  = hold_reg - 3'd1;
      state_next = (hold_reg == 3'd1) ? RUN : LU_HOLD;
    end else if (ex_branch_taken) begin
      // Squash the wrong-path instructions in IF/ID and ID; any load-use is moot.
      ifid_fl     = 1'b1;
      idex_bub    = 1'b1;
      flush_event = 1'b1;
      state_next  = RUN;
    end else if (lu) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_bub = 1'b1;
      if (LOAD_STALL == 1) begin
        state_next = RUN;
      end else begin
        hold_next  = HOLD_INIT;
        state_next = LU_HOLD;
      end
    end else begin
      state_next = RUN;
    end
  end

  // State, hold counter and saturating statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= RUN;
      ret_state_reg    <= RUN;
      hold_reg         <= 3'd0;
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      ret_state_reg <= ret_state_next;
      hold_reg      <= hold_next;
      if (!pc_we && (stall_cycles_reg != CNT_MAX)) begin
        stall_cycles_reg <= stall_cycles_reg + CNT_ONE;
      end
      if (flush_event && (flush_count_reg != CNT_MAX)) begin
        flush_count_reg <= flush_count_reg + CNT_ONE;
      end
    end
  end

  // Every enable, flush and bubble is forced low while reset is asserted.
  assign pc_write     = pc_we    & ~reset;
  assign ifid_write   = ifid_we  & ~reset;
  assign ifid_flush   = ifid_fl  & ~reset;
  assign idex_write   = idex_we  & ~reset;
  assign idex_bubble  = idex_bub & ~reset;
  assign exmem_write  = exmem_we & ~reset;
  assign state_o      = state_reg;
  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two instances (LOAD_STALL=1/CNT_W=16 and LOAD_STALL=3/CNT_W=5)
// share one randomized stimulus stream; a behavioural model predicts each cycle
// into a scoreboard queue and a monitor compares on the falling edge.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic       ifid_uses_rt = 1'b0, idex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;

  logic        pc_a, ifw_a, ifl_a, idw_a, bub_a, exw_a;
  logic        pc_b, ifw_b, ifl_b, idw_b, bub_b, exw_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] sc_a, fc_a;
  logic [4:0]  sc_b, fc_b;

  hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_a), .ifid_write(ifw_a), .ifid_flush(ifl_a), .idex_write(idw_a),
    .idex_bubble(bub_a), .exmem_write(exw_a), .state_o(st_a),
    .stall_cycles(sc_a), .flush_count(fc_a)
  );

  hazard_ctrl #(.LOAD_STALL(3), .CNT_W(5)) dut_b (
    .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_b), .ifid_write(ifw_b), .ifid_flush(ifl_b), .idex_write(idw_b),
    .idex_bubble(bub_b), .exmem_write(exw_b), .state_o(st_b),
    .stall_cycles(sc_b), .flush_count(fc_b)
  );

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}
  localparam logic [5:0] O_ZERO = 6'b000000;
  localparam logic [5:0] O_RUN  = 6'b110101;
  localparam logic [5:0] O_LU   = 6'b000111;
  localparam logic [5:0] O_BR   = 6'b111111;

  typedef struct {
    int         cyc;
    logic [5:0] o_a, o_b;
    logic [1:0] st_a, st_b;
    int         sc_a, sc_b, fc_a, fc_b;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;

  // Model state: remaining forced bubbles, waiting-on-memory flag, statistics.
  int bl[2];
  bit iw[2];
  int m_sc[2];
  int m_fc[2];

  task automatic model(input int d, input bit r, output logic [5:0] o,
                       output logic [1:0] st, output int sc, output int fc);
    int mx;
    int ls;
    bit hz;
    bit fz;
    mx = (d == 0) ? 65535 : 31;
    ls = (d == 0) ? 1 : 3;
    if (r) begin
      bl[d] = 0; iw[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
      o = O_ZERO; st = 2'd0; sc = 0; fc = 0;
      return;
    end
    st = iw[d] ? 2'd2 : ((bl[d] > 0) ? 2'd1 : 2'd0);
    sc = m_sc[d];
    fc = m_fc[d];
    hz = idex_mem_read && (idex_rt != 0) &&
         ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    fz = mem_req && !mem_ready;
    if (iw[d] && !mem_ready) begin
      o = O_ZERO;
    end else if (fz) begin
      o = O_ZERO;
      iw[d] = 1;
    end else begin
      iw[d] = 0;
      if (bl[d] > 0) begin
        o = O_LU;
        bl[d]--;
      end else if (ex_branch_taken) begin
        o = O_BR;
        if (m_fc[d] < mx) m_fc[d]++;
      end else if (hz) begin
        o = O_LU;
        bl[d] = ls - 1;
      end else begin
        o = O_RUN;
      end
    end
    if (!o[5] && (m_sc[d] < mx)) m_sc[d]++;
  endtask

  // Apply one cycle of stimulus just after the rising edge and queue the prediction.
  task automatic cyc(input bit r, input int rs, input int rt, input bit ur, input bit mrd,
                     input int irt, input bit br, input bit mq, input bit mr);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = r;
    ifid_rs         = 5'(rs);
    ifid_rt         = 5'(rt);
    ifid_uses_rt    = ur;
    idex_mem_read   = mrd;
    idex_rt         = 5'(irt);
    ex_branch_taken = br;
    mem_req         = mq;
    mem_ready       = mr;
    e.cyc = cyc_n;
    cyc_n++;
    model(0, r, e.o_a, e.st_a, e.sc_a, e.fc_a);
    model(1, r, e.o_b, e.st_b, e.sc_b, e.fc_b);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input int c, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, req);
    end
  endtask

  // Monitor: compare the DUT against the oldest prediction mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a_outputs", e.cyc, int'({pc_a, ifw_a, ifl_a, idw_a, bub_a, exw_a}), int'(e.o_a));
        check("a_state",   e.cyc, int'(st_a), int'(e.st_a));
        check("a_stalls",  e.cyc, int'(sc_a), e.sc_a);
        check("a_flushes", e.cyc, int'(fc_a), e.fc_a);
        check("b_outputs", e.cyc, int'({pc_b, ifw_b, ifl_b, idw_b, bub_b, exw_b}), int'(e.o_b));
        check("b_state",   e.cyc, int'(st_b), int'(e.st_b));
        check("b_stalls",  e.cyc, int'(sc_b), e.sc_b);
        check("b_flushes", e.cyc, int'(fc_b), e.fc_b);
        $display("[TB] cycle %0d a=%b/%0d b=%b/%0d sc=%0d/%0d fc=%0d/%0d", e.cyc,
                 {pc_a, ifw_a, ifl_a, idw_a, bub_a, exw_a}, st_a,
                 {pc_b, ifw_b, ifl_b, idw_b, bub_b, exw_b}, st_b, sc_a, sc_b, fc_a, fc_b);
      end
    end
  end

  function automatic int pick_reg();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 9;
      2: return 5;
      default: return 9;
    endcase
  endfunction

  initial begin
    int budget;
    // Reset
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use on rs: 1 bubble (a) / 3 bubbles (b)
    cyc(0, 9, 0, 0, 1, 9, 0, 0, 0);
    idle(4);
    // $zero destination, and rt match without rt use: no stall
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 3, 5, 0, 1, 5, 0, 0, 0);
    idle(1);
    // Branch with simultaneous load-use: flush wins
    cyc(0, 9, 0, 0, 1, 9, 1, 0, 0);
    idle(2);
    // Freeze during the load-use hold, then resume
    cyc(0, 9, 0, 0, 1, 9, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 9, 0, 0, 1, 9, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(4);
    // Reset while waiting on memory
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // Saturate the narrow counters
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 9, 9, 1, 1, 9, 0, 0, 0);
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) == 0), pick_reg(), pick_reg(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), pick_reg(), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end
    idle(1);
    budget = 20;
    while ((exp_q.size() > 0) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    #2;
    tests++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
